// File: rtl/flappy_pkg.sv
// Constants and state encodings shared between the pipe generator and
// the collision checker.
package flappy_pkg;

    localparam int unsigned SCREEN_W = 640;
    localparam int unsigned SCREEN_H = 480;
    localparam int unsigned PIPE_W   = 80;
    localparam int unsigned GAP_H    = 100;

    typedef enum logic [1:0] {
        QIdle = 2'b00,
        QRun  = 2'b01,
        QStop = 2'b10
    } state_t;

endpackage

// File: rtl/pipe_generator_lfsr8.sv
// Free-running 8-bit Fibonacci LFSR, polynomial x^8+x^6+x^5+x^4+1.
// The all-zero state is a lockup point, so it reloads the seed if ever seen.
module lfsr8 (
    input  logic       Clk,
    input  logic       reset_n,
    input  logic [7:0] seed,
    output logic [7:0] value
);

    logic feedback;

    assign feedback = value[7] ^ value[5] ^ value[4] ^ value[3];

    // Shift every clock; reload the seed on reset or on a zero lockup.
    always_ff @(posedge Clk or negedge reset_n) begin
        if (!reset_n) begin
            value <= seed;
        end else if (value == 8'h00) begin
            value <= seed;
        end else begin
            value <= {value[6:0], feedback};
        end
    end

endmodule

// File: rtl/pipe_generator.sv
// Pipe generator: scrolls one pipe left on each frame Tick, respawns it at
// the right edge with a pseudo-random gap height, and counts passed pipes.
module pipe_generator #(
    parameter int unsigned SCREEN_W = flappy_pkg::SCREEN_W,
    parameter int unsigned PIPE_W   = flappy_pkg::PIPE_W,
    parameter int unsigned SPEED    = 4,
    parameter int unsigned BIRD_X   = 160,
    parameter int unsigned Y_MIN    = 60,
    parameter logic [7:0]  SEED     = 8'hA5
) (
    input  logic       Clk,
    input  logic       reset_n,
    input  logic       Start,
    input  logic       Ack,
    input  logic       Tick,
    input  logic       Lose,
    output logic [9:0] X_Edge,
    output logic [9:0] Y_Edge,
    output logic [3:0] Score,
    output logic       Pipe_Valid,
    output logic       Q_Idle,
    output logic       Q_Run,
    output logic       Q_Stop
);

    import flappy_pkg::*;

    state_t      state;
    state_t      state_next;
    logic [9:0]  x_next;
    logic [9:0]  y_next;
    logic [3:0]  score_next;
    logic        passed;
    logic        passed_next;
    logic [7:0]  lfsr;
    logic [9:0]  xn;
    logic [10:0] right_edge;
    logic [9:0]  y_spawn;

    lfsr8 u_lfsr (
        .Clk     (Clk),
        .reset_n (reset_n),
        .seed    (SEED),
        .value   (lfsr)
    );

    // X after one scroll step, and the pipe's right edge at that position
    // (11 bits so the sum cannot wrap).
    assign xn         = X_Edge - 10'(SPEED);
    assign right_edge = {1'b0, xn} + 11'(PIPE_W);
    assign y_spawn    = 10'(Y_MIN) + {2'b00, lfsr};

    // Next-state and datapath update; everything holds unless a rule fires.
    always_comb begin
        state_next  = state;
        x_next      = X_Edge;
        y_next      = Y_Edge;
        score_next  = Score;
        passed_next = passed;
        case (state)
            QIdle: begin
                if (Start) begin
                    state_next  = QRun;
                    x_next      = 10'(SCREEN_W);
                    y_next      = y_spawn;
                    score_next  = 4'd0;
                    passed_next = 1'b0;
                end
            end
            QRun: begin
                if (Lose) begin
                    // Collision wins over a same-cycle Tick: freeze in place.
                    state_next = QStop;
                end else if (Tick) begin
                    if (X_Edge <= 10'(SPEED)) begin
                        x_next      = 10'(SCREEN_W);
                        y_next      = y_spawn;
                        passed_next = 1'b0;
                    end else begin
                        x_next = xn;
                        if (!passed && (right_edge < 11'(BIRD_X))) begin
                            passed_next = 1'b1;
                            if (Score != 4'd15) begin
                                score_next = Score + 4'd1;
                            end
                        end
                    end
                end
            end
            QStop: begin
                if (Ack) begin
                    state_next = QIdle;
                end
            end
            default: begin
                state_next = QIdle;
            end
        endcase
    end

    // State and datapath registers, all cleared asynchronously.
    always_ff @(posedge Clk or negedge reset_n) begin
        if (!reset_n) begin
            state  <= QIdle;
            X_Edge <= 10'(SCREEN_W);
            Y_Edge <= 10'(Y_MIN);
            Score  <= 4'd0;
            passed <= 1'b0;
        end else begin
            state  <= state_next;
            X_Edge <= x_next;
            Y_Edge <= y_next;
            Score  <= score_next;
            passed <= passed_next;
        end
    end

    assign Q_Idle     = (state == QIdle);
    assign Q_Run      = (state == QRun);
    assign Q_Stop     = (state == QStop);
    assign Pipe_Valid = (state == QRun) || (state == QStop);

endmodule

// File: tb/tb_pipe_generator.sv
// Testbench for pipe_generator: directed scenarios plus randomized traffic,
// checked every cycle against a behavioural model of the game rules.
module tb_pipe_generator;

    localparam int SCREEN_W = 640;
    localparam int PIPE_W   = 80;
    localparam int SPEED    = 4;
    localparam int BIRD_X   = 160;
    localparam int Y_MIN    = 60;
    localparam int SEED     = 8'hA5;

    logic       Clk = 1'b0;
    logic       reset_n = 1'b0;
    logic       Start = 1'b0;
    logic       Ack = 1'b0;
    logic       Tick = 1'b0;
    logic       Lose = 1'b0;
    logic [9:0] X_Edge;
    logic [9:0] Y_Edge;
    logic [3:0] Score;
    logic       Pipe_Valid;
    logic       Q_Idle;
    logic       Q_Run;
    logic       Q_Stop;

    int checks = 0;
    int errors = 0;

    pipe_generator dut (
        .Clk        (Clk),
        .reset_n    (reset_n),
        .Start      (Start),
        .Ack        (Ack),
        .Tick       (Tick),
        .Lose       (Lose),
        .X_Edge     (X_Edge),
        .Y_Edge     (Y_Edge),
        .Score      (Score),
        .Pipe_Valid (Pipe_Valid),
        .Q_Idle     (Q_Idle),
        .Q_Run      (Q_Run),
        .Q_Stop     (Q_Stop)
    );

    always #5 Clk = ~Clk;

    // Game model: st 0=idle, 1=running, 2=stopped.
    typedef struct {
        int st;
        int x;
        int y;
        int score;
        bit passed;
        int lfsr;
    } model_t;

    model_t m = '{st: 0, x: SCREEN_W, y: Y_MIN, score: 0, passed: 1'b0, lfsr: SEED};

    function automatic model_t reset_model();
        model_t r;
        r.st = 0; r.x = SCREEN_W; r.y = Y_MIN; r.score = 0; r.passed = 1'b0; r.lfsr = SEED;
        return r;
    endfunction

    function automatic model_t model_step(model_t c, bit s, bit t, bit l, bit a);
        model_t n;
        int fb;
        n = c;
        if (c.lfsr == 0) begin
            n.lfsr = SEED;
        end else begin
            fb = ((c.lfsr >> 7) ^ (c.lfsr >> 5) ^ (c.lfsr >> 4) ^ (c.lfsr >> 3)) & 1;
            n.lfsr = ((c.lfsr * 2) % 256) + fb;
        end
        if (c.st == 0) begin
            if (s) begin
                n.st = 1; n.x = SCREEN_W; n.y = Y_MIN + c.lfsr; n.score = 0; n.passed = 1'b0;
            end
        end else if (c.st == 1) begin
            if (l) begin
                n.st = 2;
            end else if (t) begin
                if (c.x <= SPEED) begin
                    n.x = SCREEN_W; n.y = Y_MIN + c.lfsr; n.passed = 1'b0;
                end else begin
                    n.x = c.x - SPEED;
                    if (!c.passed && (n.x + PIPE_W < BIRD_X)) begin
                        n.passed = 1'b1;
                        n.score = (c.score >= 15) ? 15 : c.score + 1;
                    end
                end
            end
        end else begin
            if (a) n.st = 0;
        end
        return n;
    endfunction

    always @(posedge Clk or negedge reset_n) begin
        if (!reset_n) m <= reset_model();
        else          m <= model_step(m, Start, Tick, Lose, Ack);
    end

    task automatic chk(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    // Every-cycle comparison against the model, away from the rising edge.
    always @(negedge Clk) begin
        chk("x_edge", int'(X_Edge), m.x);
        chk("y_edge", int'(Y_Edge), m.y);
        chk("score", int'(Score), m.score);
        chk("q_idle", int'(Q_Idle), int'(m.st == 0));
        chk("q_run", int'(Q_Run), int'(m.st == 1));
        chk("q_stop", int'(Q_Stop), int'(m.st == 2));
        chk("pipe_valid", int'(Pipe_Valid), int'(m.st != 0));
    end

    task automatic step(input bit s, input bit t, input bit l, input bit a);
        Start = s; Tick = t; Lose = l; Ack = a;
        @(posedge Clk);
        @(negedge Clk);
    endtask

    task automatic ticks(input int n);
        repeat (n) step(1'b0, 1'b1, 1'b0, 1'b0);
    endtask

    initial begin
        repeat (3) @(negedge Clk);
        chk("rst_x", int'(X_Edge), 640);
        chk("rst_y", int'(Y_Edge), 60);
        chk("rst_score", int'(Score), 0);
        chk("rst_idle", int'(Q_Idle), 1);
        chk("rst_valid", int'(Pipe_Valid), 0);

        // Start on the first edge after reset: LFSR still holds the seed.
        reset_n = 1'b1;
        step(1'b1, 1'b0, 1'b0, 1'b0);
        chk("start_run", int'(Q_Run), 1);
        chk("start_x", int'(X_Edge), 640);
        chk("start_y", int'(Y_Edge), 60 + 8'hA5);

        step(1'b0, 1'b1, 1'b0, 1'b0);
        chk("tick1_x", int'(X_Edge), 636);
        ticks(138);
        step(1'b0, 1'b1, 1'b0, 1'b0);
        chk("tick140_x", int'(X_Edge), 80);
        chk("tick140_score", int'(Score), 0);
        step(1'b0, 1'b1, 1'b0, 1'b0);
        chk("tick141_x", int'(X_Edge), 76);
        chk("tick141_score", int'(Score), 1);
        ticks(17);
        step(1'b0, 1'b1, 1'b0, 1'b0);
        chk("tick159_x", int'(X_Edge), 4);
        step(1'b0, 1'b1, 1'b0, 1'b0);
        chk("respawn_x", int'(X_Edge), 640);
        chk("respawn_score", int'(Score), 1);
        chk("respawn_y_range", int'(Y_Edge >= 10'd60 && Y_Edge <= 10'd315), 1);
        ticks(140);
        chk("pipe2_pre_score", int'(Score), 1);
        step(1'b0, 1'b1, 1'b0, 1'b0);
        chk("pipe2_score", int'(Score), 2);

        step(1'b0, 1'b0, 1'b1, 1'b0);
        chk("lose_stop", int'(Q_Stop), 1);
        step(1'b0, 1'b0, 1'b0, 1'b1);
        chk("ack_idle", int'(Q_Idle), 1);
        chk("ack_score_kept", int'(Score), 2);

        // Lose together with Tick at X=300.
        step(1'b1, 1'b0, 1'b0, 1'b0);
        chk("restart_score", int'(Score), 0);
        ticks(85);
        chk("at300_x", int'(X_Edge), 300);
        step(1'b0, 1'b1, 1'b1, 1'b0);
        chk("lose_tick_stop", int'(Q_Stop), 1);
        chk("lose_tick_x", int'(X_Edge), 300);
        ticks(3);
        chk("stop_frozen_x", int'(X_Edge), 300);
        step(1'b1, 1'b0, 1'b0, 1'b0);
        chk("stop_ignores_start", int'(Q_Stop), 1);
        step(1'b0, 1'b0, 1'b0, 1'b1);
        chk("ack2_idle", int'(Q_Idle), 1);
        chk("ack2_x_held", int'(X_Edge), 300);

        // Seventeen full pipe cycles saturate the score.
        step(1'b1, 1'b0, 1'b0, 1'b0);
        ticks(2720);
        chk("sat_score", int'(Score), 15);
        chk("sat_x", int'(X_Edge), 640);
        ticks(57);
        chk("pre_reset_x", int'(X_Edge), 412);

        // Asynchronous reset between clock edges.
        Tick = 1'b0;
        #2 reset_n = 1'b0;
        #1;
        chk("async_x", int'(X_Edge), 640);
        chk("async_score", int'(Score), 0);
        chk("async_idle", int'(Q_Idle), 1);
        @(negedge Clk);
        @(negedge Clk);
        reset_n = 1'b1;

        // Randomized traffic; the per-cycle compare does the checking.
        for (int i = 0; i < 4000; i++) begin
            step($urandom_range(0, 7) == 0,
                 $urandom_range(0, 1) == 1,
                 $urandom_range(0, 199) == 0,
                 $urandom_range(0, 7) == 0);
        end
        step(1'b0, 1'b0, 1'b0, 1'b0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
